// File: rtl/data_sync_rx_if.sv
// Handshake and data bundle for the CDC receive sequencer.
// OVERRUN_CNT exists only when DATA_SYNC_OVERRUN_CNT_EN is defined.
interface data_sync_rx_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 REQ_TGL_S;
  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic [BUS_WIDTH-1:0] SYNC_BUS;
  logic                 SYNC_VALID;
  logic                 SYNC_READY;
  logic                 ACK_TGL;
  logic                 BUSY;
  logic                 OVERRUN;
`ifdef DATA_SYNC_OVERRUN_CNT_EN
  logic [CNT_WIDTH-1:0] OVERRUN_CNT;
`endif

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  modport master (
    output REQ_TGL_S, UNSYNC_BUS, SYNC_READY,
`ifdef DATA_SYNC_OVERRUN_CNT_EN
    input  OVERRUN_CNT,
`endif
    input  SYNC_BUS, SYNC_VALID, ACK_TGL, BUSY, OVERRUN
  );

  modport slave (
    input  REQ_TGL_S, UNSYNC_BUS, SYNC_READY,
`ifdef DATA_SYNC_OVERRUN_CNT_EN
    output OVERRUN_CNT,
`endif
    output SYNC_BUS, SYNC_VALID, ACK_TGL, BUSY, OVERRUN
  );
endinterface

// File: rtl/data_sync_rx_ctrl.sv
// Receive-side CDC sequencer: request-toggle edge -> settle wait -> capture -> valid/ready -> ack toggle.
// Optional saturating overrun counter enabled by DATA_SYNC_OVERRUN_CNT_EN.
module data_sync_rx_ctrl #(
  parameter int BUS_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic           CLK,
  input  logic           RST,
  data_sync_rx_if.slave  bus
);
  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 0..15");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 req_prev;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 ack_q, ack_d;
  logic                 ovr_q, ovr_d;
  logic                 req_edge;
  logic                 discard;

  assign req_edge = bus.REQ_TGL_S ^ req_prev;
  // Any edge seen outside IDLE is dropped, even on the cycle HOLD completes.
  assign discard  = req_edge && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ack_d   = ack_q;
    ovr_d   = ovr_q | discard;
    case (state_q)
      S_IDLE: if (req_edge) begin
        cnt_d   = SETTLE;
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        data_d  = bus.UNSYNC_BUS;
        vld_d   = 1'b1;
        state_d = S_HOLD;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_HOLD: if (bus.SYNC_READY) begin
        vld_d   = 1'b0;
        ack_d   = ~ack_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    req_prev <= bus.REQ_TGL_S;
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.SYNC_BUS   = data_q;
  assign bus.SYNC_VALID = vld_q;
  assign bus.ACK_TGL    = ack_q;
  assign bus.OVERRUN    = ovr_q;
  assign bus.BUSY       = (state_q != S_IDLE);

`ifdef DATA_SYNC_OVERRUN_CNT_EN
  logic [CNT_WIDTH-1:0] ocnt_q;

  always_ff @(posedge CLK) begin
    if (RST)                          ocnt_q <= '0;
    else if (discard && ocnt_q != '1) ocnt_q <= ocnt_q + 1'b1;
  end

  assign bus.OVERRUN_CNT = ocnt_q;
`endif
endmodule

// File: tb/tb_data_sync_rx_ctrl.sv
// Bench for data_sync_rx_ctrl: dut_a uses SETTLE_CYCLES=1, dut_b uses SETTLE_CYCLES=0 and CNT_WIDTH=2.
// Expected words are queued when a toggle is driven and popped at each observed handshake.
module tb_data_sync_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  data_sync_rx_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) if_a ();
  data_sync_rx_if #(.BUS_WIDTH(8), .CNT_WIDTH(2)) if_b ();

  data_sync_rx_ctrl #(.BUS_WIDTH(8), .SETTLE_CYCLES(1), .CNT_WIDTH(8)) dut_a (
    .CLK(clk), .RST(rst), .bus(if_a)
  );
  data_sync_rx_ctrl #(.BUS_WIDTH(8), .SETTLE_CYCLES(0), .CNT_WIDTH(2)) dut_b (
    .CLK(clk), .RST(rst), .bus(if_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.REQ_TGL_S = 1'b0; if_a.UNSYNC_BUS = 8'h00; if_a.SYNC_READY = 1'b0;
    if_b.REQ_TGL_S = 1'b1; if_b.UNSYNC_BUS = 8'h00; if_b.SYNC_READY = 1'b0;
    rst = 1'b1;
    step(); step();
    n_tests++;
    if ({if_a.SYNC_BUS, if_a.SYNC_VALID, if_a.ACK_TGL, if_a.BUSY, if_a.OVERRUN} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_a: got bus=%h v=%b ack=%b busy=%b ovr=%b expected all 0",
               if_a.SYNC_BUS, if_a.SYNC_VALID, if_a.ACK_TGL, if_a.BUSY, if_a.OVERRUN);
    end
    n_tests++;
    if ({if_b.SYNC_VALID, if_b.ACK_TGL, if_b.BUSY, if_b.OVERRUN} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%b ack=%b busy=%b ovr=%b expected all 0",
               if_b.SYNC_VALID, if_b.ACK_TGL, if_b.BUSY, if_b.OVERRUN);
    end
    rst = 1'b0;
    step(); step();
    // REQ_TGL_S=1 was held through reset on dut_b; no edge may appear after release.
    n_tests++;
    if (if_b.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_spurious_edge: got busy=%b expected 0", if_b.BUSY);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    if_a.SYNC_READY = 1'b1; if_a.UNSYNC_BUS = 8'hA5;
    if_a.REQ_TGL_S = ~if_a.REQ_TGL_S; exp_a.push_back(8'hA5);
    step();
    n_tests++;
    if (if_a.BUSY !== 1'b1 || if_a.SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL basic_t: got busy=%b v=%b expected 1 0", if_a.BUSY, if_a.SYNC_VALID);
    end
    step();
    n_tests++;
    if (if_a.SYNC_VALID !== 1'b0 || if_a.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL basic_t1: got v=%b busy=%b expected 0 1", if_a.SYNC_VALID, if_a.BUSY);
    end
    step();
    n_tests++;
    if (if_a.SYNC_VALID !== 1'b1) begin
      n_fail++; $display("FAIL basic_t2_valid: got %b expected 1", if_a.SYNC_VALID);
    end
    n_tests++;
    if (exp_a.size() == 0) begin
      n_fail++; $display("FAIL basic_sb: got empty scoreboard expected a word");
    end else begin
      w = exp_a.pop_front();
      if (if_a.SYNC_BUS !== w) begin
        n_fail++; $display("FAIL basic_word: got %h expected %h", if_a.SYNC_BUS, w);
      end
    end
    step();
    n_tests++;
    if (if_a.SYNC_VALID !== 1'b0 || if_a.ACK_TGL !== 1'b1 || if_a.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL basic_t3: got v=%b ack=%b busy=%b expected 0 1 0",
                         if_a.SYNC_VALID, if_a.ACK_TGL, if_a.BUSY);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    if_a.SYNC_READY = 1'b0; if_a.UNSYNC_BUS = 8'hA5;
    if_a.REQ_TGL_S = ~if_a.REQ_TGL_S; exp_a.push_back(8'hA5);
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (if_a.SYNC_VALID !== 1'b1 || if_a.SYNC_BUS !== 8'hA5 || if_a.ACK_TGL !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b bus=%h ack=%b expected 1 a5 1",
                           i, if_a.SYNC_VALID, if_a.SYNC_BUS, if_a.ACK_TGL);
      end
      step();
    end
    if_a.SYNC_READY = 1'b1;
    n_tests++;
    if (exp_a.size() == 0) begin
      n_fail++; $display("FAIL bp_sb: got empty scoreboard expected a word");
    end else begin
      w = exp_a.pop_front();
      if (if_a.SYNC_BUS !== w) begin
        n_fail++; $display("FAIL bp_word: got %h expected %h", if_a.SYNC_BUS, w);
      end
    end
    step();
    n_tests++;
    if (if_a.ACK_TGL !== 1'b0 || if_a.SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL bp_ack: got ack=%b v=%b expected 0 0", if_a.ACK_TGL, if_a.SYNC_VALID);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    logic       bad;
    if_a.SYNC_READY = 1'b0; if_a.UNSYNC_BUS = 8'hA5;
    if_a.REQ_TGL_S = ~if_a.REQ_TGL_S; exp_a.push_back(8'hA5);
    step(); step(); step();
    if_a.UNSYNC_BUS = 8'h5A; if_a.REQ_TGL_S = ~if_a.REQ_TGL_S;
    step();
    n_tests++;
    if (if_a.OVERRUN !== 1'b1 || if_a.SYNC_BUS !== 8'hA5 || if_a.SYNC_VALID !== 1'b1) begin
      n_fail++; $display("FAIL ovr_flag: got ovr=%b bus=%h v=%b expected 1 a5 1",
                         if_a.OVERRUN, if_a.SYNC_BUS, if_a.SYNC_VALID);
    end
    step(); step();
    if_a.SYNC_READY = 1'b1;
    n_tests++;
    if (exp_a.size() == 0) begin
      n_fail++; $display("FAIL ovr_sb: got empty scoreboard expected a word");
    end else begin
      w = exp_a.pop_front();
      if (if_a.SYNC_BUS !== w) begin
        n_fail++; $display("FAIL ovr_word: got %h expected %h", if_a.SYNC_BUS, w);
      end
    end
    step();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if_a.SYNC_VALID !== 1'b0 || if_a.ACK_TGL !== 1'b1) bad = 1'b1;
      step();
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL ovr_single_ack: got extra valid or ack flip (v=%b ack=%b) expected v=0 ack=1",
                         if_a.SYNC_VALID, if_a.ACK_TGL);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic bad;
    if_a.REQ_TGL_S = 1'b1;
    if_a.UNSYNC_BUS = 8'h77;
    step();
    n_tests++;
    if (if_a.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_entry: got busy=%b expected 1", if_a.BUSY);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({if_a.SYNC_BUS, if_a.SYNC_VALID, if_a.ACK_TGL, if_a.BUSY, if_a.OVERRUN} !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid: got bus=%h v=%b ack=%b busy=%b ovr=%b expected all 0",
                         if_a.SYNC_BUS, if_a.SYNC_VALID, if_a.ACK_TGL, if_a.BUSY, if_a.OVERRUN);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_a.SYNC_VALID !== 1'b0 || if_a.BUSY !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rst_quiet: got valid/busy activity after reset expected none");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    if_b.SYNC_READY = 1'b1; if_b.UNSYNC_BUS = 8'h3C;
    if_b.REQ_TGL_S = ~if_b.REQ_TGL_S; exp_b.push_back(8'h3C);
    step();
    n_tests++;
    if (if_b.BUSY !== 1'b1 || if_b.SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL b2b_t0: got busy=%b v=%b expected 1 0", if_b.BUSY, if_b.SYNC_VALID);
    end
    step();
    n_tests++;
    if (if_b.SYNC_VALID !== 1'b1 || exp_b.size() == 0) begin
      n_fail++; $display("FAIL b2b_v1: got v=%b queued=%0d expected 1 1", if_b.SYNC_VALID, exp_b.size());
    end else begin
      w = exp_b.pop_front();
      if (if_b.SYNC_BUS !== w) begin
        n_fail++; $display("FAIL b2b_word1: got %h expected %h", if_b.SYNC_BUS, w);
      end
    end
    step();
    n_tests++;
    if (if_b.SYNC_VALID !== 1'b0 || if_b.ACK_TGL !== 1'b1 || if_b.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ack1: got v=%b ack=%b busy=%b expected 0 1 0",
                         if_b.SYNC_VALID, if_b.ACK_TGL, if_b.BUSY);
    end
    if_b.UNSYNC_BUS = 8'hC3; if_b.REQ_TGL_S = ~if_b.REQ_TGL_S; exp_b.push_back(8'hC3);
    step();
    n_tests++;
    if (if_b.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept2: got busy=%b expected 1", if_b.BUSY);
    end
    step();
    n_tests++;
    if (if_b.SYNC_VALID !== 1'b1 || exp_b.size() == 0) begin
      n_fail++; $display("FAIL b2b_v2: got v=%b queued=%0d expected 1 1", if_b.SYNC_VALID, exp_b.size());
    end else begin
      w = exp_b.pop_front();
      if (if_b.SYNC_BUS !== w) begin
        n_fail++; $display("FAIL b2b_word2: got %h expected %h", if_b.SYNC_BUS, w);
      end
    end
    step();
    n_tests++;
    if (if_b.ACK_TGL !== 1'b0 || if_b.SYNC_VALID !== 1'b0 || if_b.OVERRUN !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got ack=%b v=%b ovr=%b expected 0 0 0",
                         if_b.ACK_TGL, if_b.SYNC_VALID, if_b.OVERRUN);
    end
  endtask

`ifdef DATA_SYNC_OVERRUN_CNT_EN
  task automatic test_overrun_cnt();
    logic [7:0] w;
    if_b.SYNC_READY = 1'b0; if_b.UNSYNC_BUS = 8'h11;
    if_b.REQ_TGL_S = ~if_b.REQ_TGL_S; exp_b.push_back(8'h11);
    step();
    n_tests++;
    if (if_b.OVERRUN_CNT !== 2'd0) begin
      n_fail++; $display("FAIL ocnt_start: got %0d expected 0", if_b.OVERRUN_CNT);
    end
    if_b.REQ_TGL_S = ~if_b.REQ_TGL_S;
    step();
    n_tests++;
    if (if_b.OVERRUN_CNT !== 2'd1 || if_b.OVERRUN !== 1'b1) begin
      n_fail++; $display("FAIL ocnt_one: got cnt=%0d ovr=%b expected 1 1", if_b.OVERRUN_CNT, if_b.OVERRUN);
    end
    for (int i = 0; i < 4; i++) begin
      if_b.REQ_TGL_S = ~if_b.REQ_TGL_S;
      step();
    end
    n_tests++;
    if (if_b.OVERRUN_CNT !== 2'd3 || if_b.OVERRUN !== 1'b1) begin
      n_fail++; $display("FAIL ocnt_sat: got cnt=%0d ovr=%b expected 3 1", if_b.OVERRUN_CNT, if_b.OVERRUN);
    end
    if_b.SYNC_READY = 1'b1;
    n_tests++;
    if (exp_b.size() == 0) begin
      n_fail++; $display("FAIL ocnt_sb: got empty scoreboard expected a word");
    end else begin
      w = exp_b.pop_front();
      if (if_b.SYNC_BUS !== w) begin
        n_fail++; $display("FAIL ocnt_word: got %h expected %h", if_b.SYNC_BUS, w);
      end
    end
    step();
    n_tests++;
    if (if_b.ACK_TGL !== 1'b1 || if_b.SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL ocnt_ack: got ack=%b v=%b expected 1 0", if_b.ACK_TGL, if_b.SYNC_VALID);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef DATA_SYNC_OVERRUN_CNT_EN
    test_overrun_cnt();
`endif
    n_tests++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d/%0d words left expected 0/0", exp_a.size(), exp_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_sync_rx_ctrl.md
Name: data_sync_rx_ctrl

Overview:
Receive-side sequencer for multi-bit clock-domain crossing. Watches a request toggle that has already passed through a bit synchronizer. Waits a programmable settle time, captures the source-stable data bus, and presents it downstream with valid/ready. Returns an acknowledge toggle, which is synchronized back to the source domain by a separate bit synchronizer.

Parameters:
BUS_WIDTH, 8, width of the crossed data bus
SETTLE_CYCLES, 1, cycles between request-edge detection and bus capture; legal range 0..15
CNT_WIDTH, 8, width of the overrun counter (used only with the optional feature)

Ports:
CLK  input  1  destination-domain clock
RST  input  1  reset; synchronous, active-high
REQ_TGL_S  input  1  synchronized request toggle; each level change = one new word
UNSYNC_BUS  input  BUS_WIDTH  source-domain data; held stable by the source from its toggle until it sees ACK
SYNC_BUS  output  BUS_WIDTH  captured word, registered
SYNC_VALID  output  1  SYNC_BUS holds an unconsumed word
SYNC_READY  input  1  downstream accepts the word
ACK_TGL  output  1  acknowledge toggle, flips once per consumed word
BUSY  output  1  high whenever the FSM is not in IDLE
OVERRUN  output  1  sticky; a request edge arrived while BUSY

Behaviour:
- Reset (RST=1 at posedge CLK):
  - state=IDLE, SYNC_BUS=0, SYNC_VALID=0, ACK_TGL=0, OVERRUN=0, settle counter=0.
  - req_prev loads REQ_TGL_S, so no spurious edge after release.
  - Reset overrides every event in the same cycle, including a reset mid-transfer.
- Edge detect:
  - req_prev samples REQ_TGL_S every posedge.
  - edge = REQ_TGL_S XOR req_prev (combinational).
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - On edge at posedge t: cnt<=SETTLE_CYCLES, go to WAIT.
  - No edge: stay in IDLE.
- WAIT:
  - If cnt==0 at a posedge: SYNC_BUS<=UNSYNC_BUS, SYNC_VALID<=1, go to HOLD.
  - Otherwise cnt<=cnt-1.
  - Result: SYNC_VALID rises at posedge t+1+SETTLE_CYCLES.
- HOLD:
  - SYNC_BUS and SYNC_VALID are held.
  - On a posedge with SYNC_READY=1: SYNC_VALID<=0, ACK_TGL<=~ACK_TGL, go to IDLE.
  - SYNC_READY is ignored in IDLE and WAIT.
- Back-to-back: an edge sampled in IDLE on the cycle after the HOLD exit is accepted normally. Minimum spacing between transfers is SETTLE_CYCLES+3 cycles.
- Overrun: an edge while in WAIT or HOLD is discarded; it does not restart the counter or recapture. OVERRUN<=1, cleared only by RST.
- BUSY = (state != IDLE), combinational from the state register.
- Simultaneous edge and HOLD handshake on the same posedge: the handshake completes and the edge counts as an overrun (state was HOLD).
- SETTLE_CYCLES=0: capture at t+1; WAIT lasts exactly one cycle.

Optional Feature:
- Macro: DATA_SYNC_OVERRUN_CNT_EN.
- Defined:
  - Adds output OVERRUN_CNT [CNT_WIDTH-1:0], reset 0.
  - Increments by 1 on each discarded edge and saturates at all-ones.
  - OVERRUN behaves as without the macro.
- Undefined: the port and counter do not exist; CNT_WIDTH is unused.

Test Plan:
1. SETTLE=1, reset, REQ_TGL_S 0->1 with UNSYNC_BUS=0xA5, SYNC_READY=1 -> SYNC_VALID=1 and SYNC_BUS=0xA5 at posedge t+2, SYNC_VALID=0 and ACK_TGL=1 at t+3, BUSY high t+1..t+3 then low.
2. Backpressure: same as scenario 1 with SYNC_READY=0 for 5 cycles -> SYNC_VALID/SYNC_BUS held 0xA5, ACK_TGL stays 0; ACK_TGL flips one posedge after SYNC_READY=1.
3. Overrun: second toggle during HOLD, bus changed to 0x5A -> OVERRUN=1, SYNC_BUS stays 0xA5, exactly one ACK_TGL flip, no second SYNC_VALID.
4. Reset mid-WAIT with REQ_TGL_S=1 held -> all outputs 0 after reset; no SYNC_VALID for 20 cycles after release.
5. SETTLE=0, two transfers 0x3C then 0xC3 at minimum spacing, SYNC_READY=1 -> SYNC_VALID one cycle after each edge, correct words in order, ACK_TGL 0->1->0, OVERRUN=0.
6. With DATA_SYNC_OVERRUN_CNT_EN, CNT_WIDTH=2: 5 discarded edges -> OVERRUN_CNT=3 (saturated), OVERRUN=1.
